// File: rtl/prefix_adder_pkg.sv
// Shared constants and helpers for the Kogge-Stone prefix adder.
package prefix_adder_pkg;

  localparam int WIDTH_DEFAULT = 6;

  // Input position 0 is reserved for c_in, so the tree spans WIDTH+1 positions.
  function automatic int prefix_levels(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// One prefix-operator node: (g,p) = (g_hi | p_hi&g_lo, p_hi&p_lo).
module prefix_cell #(
  parameter bit GREY = 1'b0
) (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  // A grey node's group already reaches c_in, so its propagate is never consumed.
  assign p = GREY ? 1'b0 : (p_hi & p_lo);

endmodule

// File: rtl/prefix_adder.sv
// Kogge-Stone adder S = X + Y + c_in with one output register.
// Free-running datapath: no valid/ready, one operand set accepted on every edge.
module prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             c_in,
  output logic [WIDTH:0]   S
);

  localparam int LEVELS = prefix_levels(WIDTH);

  // Position j of the tree holds bit j-1; position 0 is c_in (G=c_in, P=0).
  logic [WIDTH:0] g_lvl [0:LEVELS];
  logic [WIDTH:0] p_lvl [0:LEVELS];
  logic [WIDTH:0] sum_next;

  assign g_lvl[0] = {X & Y, c_in};
  assign p_lvl[0] = {X ^ Y, 1'b0};

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int DIST = 1 << l;
    for (genvar j = 0; j <= WIDTH; j++) begin : g_node
      if (j >= DIST) begin : g_cell
        prefix_cell #(
          .GREY((j < 2 * DIST) ? 1'b1 : 1'b0)
        ) u_cell (
          .g_hi (g_lvl[l][j]),
          .p_hi (p_lvl[l][j]),
          .g_lo (g_lvl[l][j-DIST]),
          .p_lo (p_lvl[l][j-DIST]),
          .g    (g_lvl[l+1][j]),
          .p    (p_lvl[l+1][j])
        );
      end else begin : g_pass
        assign g_lvl[l+1][j] = g_lvl[l][j];
        assign p_lvl[l+1][j] = p_lvl[l][j];
      end
    end
  end

  // After the last level g_lvl[LEVELS][j] is the carry into bit j.
  assign sum_next = {g_lvl[LEVELS][WIDTH],
                     p_lvl[0][WIDTH:1] ^ g_lvl[LEVELS][WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      S <= '0;
    end else begin
      S <= sum_next;
    end
  end

endmodule

// File: tb/tb_prefix_adder.sv
// Scoreboard bench for prefix_adder: driver pushes expected sums, monitor pops one per edge.
module tb_prefix_adder;

  localparam int W = 6;

  logic         clk;
  logic         rst;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         c_in;
  logic [W:0]   s;

  logic [W:0] exp_q[$];
  string      name_q[$];
  int         checks;
  int         failures;

  prefix_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .X    (x),
    .Y    (y),
    .c_in (c_in),
    .S    (s)
  );

  // Clock and reset-time defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst  = 1'b1;
    x    = '0;
    y    = '0;
    c_in = 1'b0;
  end

  // Driver: apply one operand set at the falling edge and record the sum it must produce.
  task automatic drive(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W:0] expv, input string nm);
    @(negedge clk);
    rst  = r;
    x    = a;
    y    = b;
    c_in = ci;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  // Monitor: S is valid every cycle, so each edge retires one queued expectation.
  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (s !== e) begin
          failures++;
          $display("FAIL %s: S=%0d expected %0d", n, s, e);
        end
      end
    end
  end

  initial begin
    logic [W:0] model;
    int         budget;

    // Reset dominates all-ones inputs, then release
    drive(1'b1, 6'h3F, 6'h3F, 1'b1, 7'd0,   "reset_dominates");
    drive(1'b1, 6'h3F, 6'h3F, 1'b1, 7'd0,   "reset_hold");
    drive(1'b0, 6'h3F, 6'h3F, 1'b1, 7'd127, "release_max_cin");

    // Directed boundaries
    drive(1'b0, 6'b111111, 6'b000000, 1'b1, 7'b1000000, "carry_full_width");
    drive(1'b0, 6'b101010, 6'b010101, 1'b1, 7'd64,      "alternating_cin");
    drive(1'b0, 6'd0,      6'd0,      1'b0, 7'd0,       "all_zero");
    drive(1'b0, 6'd63,     6'd63,     1'b0, 7'd126,     "max_no_cin");
    drive(1'b0, 6'd0,      6'd0,      1'b1, 7'd1,       "cin_only");
    drive(1'b0, 6'd1,      6'd1,      1'b0, 7'd2,       "b2b_first");
    drive(1'b0, 6'd63,     6'd1,      1'b0, 7'd64,      "b2b_second");
    drive(1'b0, 6'd21,     6'd10,     1'b0, 7'd31,      "no_carry");
    drive(1'b0, 6'd32,     6'd32,     1'b1, 7'd65,      "msb_carry_cin");

    // Exhaustive sweep, one pair per cycle
    for (int ci = 0; ci < 2; ci++) begin
      for (int a = 0; a < (1 << W); a++) begin
        for (int b = 0; b < (1 << W); b++) begin
          model = 7'(a) + 7'(b) + 7'(ci);
          drive(1'b0, W'(a), W'(b), 1'(ci), model, "exhaustive");
        end
      end
    end

    // Random stream with a one-cycle reset in the middle
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      a  = W'($urandom_range(0, (1 << W) - 1));
      b  = W'($urandom_range(0, (1 << W) - 1));
      ci = 1'($urandom_range(0, 1));
      if (i == 20) begin
        drive(1'b1, a, b, ci, 7'd0, "mid_stream_reset");
      end else begin
        model = 7'(a) + 7'(b) + 7'(ci);
        drive(1'b0, a, b, ci, model, "random_stream");
      end
    end

    // Drain the scoreboard within a bounded number of cycles
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
